logic_chan_bank: RTL and testbench
==================================

# logic_chan_bank

Parametrised multi-channel holding-register bank, the successor to the single 4-bit logic register with its derived enable bit. It holds NUM_CH independent WIDTH-bit channels, writable through a valid/ready port in load or serial-shift mode, readable through a registered read port. Each channel carries an explicit valid flag that replaces the unwritten-X default, and drives a per-channel enable. A multi-cycle sequenced clear walks all channels.

## Interface
- WIDTH, 4: data bits per channel, ≥2.
- NUM_CH, 4: channel count, ≥1, need not be a power of 2.
- CH_W (localparam): max(1, $clog2(NUM_CH)).
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  start clear sequence (sampled in IDLE only).
- wr_valid  in  1  write request.
- wr_ready  out  1  write accept, combinational: (state==IDLE) && !clr.
- wr_mode  in  1  0 = load wr_data; 1 = shift left, wr_data[0] enters LSB.
- wr_ch  in  CH_W  target channel.
- wr_data  in  WIDTH  write data.
- rd_en  in  1  read request, accepted in any state.
- rd_ch  in  CH_W  read channel.
- rd_ack  out  1  registered, pulses 1 cycle after rd_en.
- rd_hit  out  1  registered, channel valid at sample time.
- rd_data  out  WIDTH  registered read data; 0 when !rd_hit.
- ch_valid  out  NUM_CH  per-channel written flag.
- en  out  NUM_CH  en[i] = data[i][0] & ch_valid[i], combinational.
- err  out  1  registered, 1-cycle pulse on accepted write to wr_ch ≥ NUM_CH.

## Operation
- States: IDLE, CLEAR. CLEAR keeps an internal CH_W-bit index.
- IDLE & clr=1 → CLEAR, index=0. A write offered in that cycle is not accepted.
- CLEAR: each cycle zeroes data[index] and ch_valid[index], then increments index. After index==NUM_CH-1 → IDLE. CLEAR therefore lasts exactly NUM_CH cycles. clr is ignored while in CLEAR.
- Accepted write (wr_valid && wr_ready):
  - Load: data[wr_ch] ← wr_data.
  - Shift: data[wr_ch] ← {data[wr_ch][WIDTH-2:0], wr_data[0]}.
  - Either mode sets ch_valid[wr_ch].
  - A shift into an invalid channel shifts from 0.
- wr_ch ≥ NUM_CH: handshake completes, no state change, err pulses next cycle.
- Read: on rd_en, the next cycle shows rd_ack=1, rd_hit=ch_valid[rd_ch], and rd_data=data[rd_ch] (or 0 if not hit). Values are taken before any same-cycle write (read-before-write). rd_ch ≥ NUM_CH gives rd_hit=0, rd_data=0, no err.
- A read during CLEAR returns the pre-clear contents of channels not yet cleared.

## Timing
- Reset values:
  - state=IDLE, all data=0, ch_valid=0, en=0.
  - rd_ack=0, rd_hit=0, rd_data=0, err=0.
  - wr_ready=1 once rst deasserts, if clr=0.
- Write latency: data and ch_valid update on the accepting edge; en reflects it in the same following cycle.
- Read latency: exactly 1 cycle; back-to-back rd_en gives back-to-back rd_ack.
- rst asserted mid-CLEAR or mid-write: immediate return to reset values, with no partial completion.
- Simultaneous write to channel k and CLEAR index k is impossible, because wr_ready=0 throughout CLEAR.

## Test plan
- Reset, then read ch0–3 → rd_ack=1, rd_hit=0, rd_data=0 each; en=4'b0000, ch_valid=4'b0000.
- Load ch2=4'hB, then read ch2 → rd_hit=1, rd_data=4'hB; en=4'b0100, ch_valid=4'b0100.
- Shift bits 1,0,1,1 into empty ch1 → data=4'b1011, en[1]=1; a fifth shift of 0 → 4'b0110, en[1]=0.
- Load ch0=4'h5 and read ch0 in the same cycle → rd_data=0, rd_hit=0; read next cycle → 4'h5.
- With all channels loaded, assert clr alongside wr_valid → write not accepted; wr_ready=0 for exactly 4 cycles; afterwards ch_valid=0, en=0. Also assert rst mid-CLEAR → immediate reset values.
- NUM_CH=3 build: write wr_ch=3 → accepted, err pulses 1 cycle, ch_valid unchanged.

Source files
------------

// File: rtl/logic_chan_bank.sv
// logic_chan_bank: NUM_CH-channel holding-register bank with load/shift writes, registered reads and sequenced clear.
module logic_chan_bank #(
  parameter int WIDTH = 4,
  parameter int NUM_CH = 4,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              wr_mode,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [CH_W-1:0]   rd_ch,
  output logic              rd_ack,
  output logic              rd_hit,
  output logic [WIDTH-1:0]  rd_data,
  output logic [NUM_CH-1:0] ch_valid,
  output logic [NUM_CH-1:0] en,
  output logic              err
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state_q, state_d;
  logic [CH_W-1:0] idx_q, idx_d;
  logic [NUM_CH-1:0][WIDTH-1:0] data_q, data_d;
  logic [NUM_CH-1:0] ch_valid_q, ch_valid_d;
  logic rd_ack_q, rd_ack_d, rd_hit_q, rd_hit_d, err_q, err_d, wr_ok, wr_hit;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  assign wr_ready = (state_q == IDLE) && !clr;
  assign wr_ok = wr_valid && wr_ready;
  assign rd_ack = rd_ack_q;
  assign rd_hit = rd_hit_q;
  assign rd_data = rd_data_q;
  assign ch_valid = ch_valid_q;
  assign err = err_q;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    data_d = data_q;
    ch_valid_d = ch_valid_q;
    wr_hit = 1'b0;
    rd_ack_d = rd_en;
    rd_hit_d = 1'b0;
    rd_data_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      en[i] = data_q[i][0] & ch_valid_q[i];
      // reads sample the current contents, so a same-cycle write is not visible
      if (rd_en && rd_ch == CH_W'(i) && ch_valid_q[i]) begin
        rd_hit_d = 1'b1;
        rd_data_d = data_q[i];
      end
      if (wr_ch == CH_W'(i)) wr_hit = 1'b1;
      if (wr_ok && wr_ch == CH_W'(i)) begin
        data_d[i] = wr_mode ? {(ch_valid_q[i] ? data_q[i][WIDTH-2:0] : {(WIDTH-1){1'b0}}), wr_data[0]} : wr_data;
        ch_valid_d[i] = 1'b1;
      end
      if (state_q == CLEAR && idx_q == CH_W'(i)) begin
        data_d[i] = '0;
        ch_valid_d[i] = 1'b0;
      end
    end
    err_d = wr_ok && !wr_hit;
    if (state_q == IDLE && clr) begin
      state_d = CLEAR;
      idx_d = '0;
    end
    if (state_q == CLEAR) begin
      idx_d = idx_q + 1'b1;
      state_d = (idx_q == CH_W'(NUM_CH - 1)) ? IDLE : CLEAR;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      data_q <= '0;
      ch_valid_q <= '0;
      rd_ack_q <= 1'b0;
      rd_hit_q <= 1'b0;
      rd_data_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      data_q <= data_d;
      ch_valid_q <= ch_valid_d;
      rd_ack_q <= rd_ack_d;
      rd_hit_q <= rd_hit_d;
      rd_data_q <= rd_data_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_logic_chan_bank.sv
// tb_logic_chan_bank: directed table, corner sequences and randomized run against a channel-array model.
module tb_logic_chan_bank;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic clr = 0, wr_valid = 0, wr_mode = 0, rd_en = 0;
  logic [1:0] wr_ch = 0, rd_ch = 0;
  logic [3:0] wr_data = 0;
  logic wr_ready, rd_ack, rd_hit, err;
  logic [3:0] rd_data, ch_valid, en;
  logic u_clr = 0, u_wr_valid = 0, u_wr_mode = 0, u_rd_en = 0;
  logic [1:0] u_wr_ch = 0, u_rd_ch = 0;
  logic [3:0] u_wr_data = 0;
  logic u_wr_ready, u_rd_ack, u_rd_hit, u_err;
  logic [3:0] u_rd_data;
  logic [2:0] u_ch_valid, u_en;
  logic_chan_bank #(.WIDTH(4), .NUM_CH(4)) dut (
    .clk(clk), .rst(rst), .clr(clr), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_mode(wr_mode),
    .wr_ch(wr_ch), .wr_data(wr_data), .rd_en(rd_en), .rd_ch(rd_ch), .rd_ack(rd_ack), .rd_hit(rd_hit),
    .rd_data(rd_data), .ch_valid(ch_valid), .en(en), .err(err));
  logic_chan_bank #(.WIDTH(4), .NUM_CH(3)) dut3 (
    .clk(clk), .rst(rst), .clr(u_clr), .wr_valid(u_wr_valid), .wr_ready(u_wr_ready), .wr_mode(u_wr_mode),
    .wr_ch(u_wr_ch), .wr_data(u_wr_data), .rd_en(u_rd_en), .rd_ch(u_rd_ch), .rd_ack(u_rd_ack), .rd_hit(u_rd_hit),
    .rd_data(u_rd_data), .ch_valid(u_ch_valid), .en(u_en), .err(u_err));
  int nvec = 0, nerr = 0;
  logic [3:0] md [4];
  bit mv [4];
  int clr_left = 0;
  typedef struct {
    bit c, wv, wm;
    bit [1:0] wch;
    bit [3:0] wd;
    bit re;
    bit [1:0] rch;
    bit eh;
    bit [3:0] ed, een, ev;
  } vec_t;
  vec_t tbl [15];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      md[i] = 0;
      mv[i] = 0;
    end
    clr_left = 0;
  endtask
  task automatic cyc(input bit c, wv, wm, input bit [1:0] wch, input bit [3:0] wd, input bit re, input bit [1:0] rch);
    bit eh;
    bit [3:0] ed, ee, evv;
    clr = c; wr_valid = wv; wr_mode = wm; wr_ch = wch; wr_data = wd; rd_en = re; rd_ch = rch;
    #1;
    chk("wr_ready", wr_ready, (clr_left == 0) && !c);
    eh = re && mv[rch];
    ed = eh ? md[rch] : 4'h0;
    if (clr_left > 0) begin
      md[4 - clr_left] = 0;
      mv[4 - clr_left] = 0;
      clr_left--;
    end else if (c) clr_left = 4;
    else if (wv) begin
      md[wch] = wm ? {(mv[wch] ? md[wch][2:0] : 3'b0), wd[0]} : wd;
      mv[wch] = 1;
    end
    for (int i = 0; i < 4; i++) begin
      ee[i] = md[i][0] & mv[i];
      evv[i] = mv[i];
    end
    @(posedge clk);
    #1;
    chk("rd_ack", rd_ack, re);
    chk("rd_hit", rd_hit, eh);
    chk("rd_data", rd_data, ed);
    chk("err", err, 0);
    chk("ch_valid", ch_valid, evv);
    chk("en", en, ee);
  endtask
  initial begin
    int n;
    tbl[0]  = '{0, 0, 0, 2'd0, 4'h0, 1, 2'd0, 0, 4'h0, 4'b0000, 4'b0000};
    tbl[1]  = '{0, 0, 0, 2'd0, 4'h0, 1, 2'd1, 0, 4'h0, 4'b0000, 4'b0000};
    tbl[2]  = '{0, 0, 0, 2'd0, 4'h0, 1, 2'd2, 0, 4'h0, 4'b0000, 4'b0000};
    tbl[3]  = '{0, 0, 0, 2'd0, 4'h0, 1, 2'd3, 0, 4'h0, 4'b0000, 4'b0000};
    tbl[4]  = '{0, 1, 0, 2'd2, 4'hB, 0, 2'd0, 0, 4'h0, 4'b0100, 4'b0100};
    tbl[5]  = '{0, 0, 0, 2'd0, 4'h0, 1, 2'd2, 1, 4'hB, 4'b0100, 4'b0100};
    tbl[6]  = '{0, 1, 1, 2'd1, 4'h1, 0, 2'd0, 0, 4'h0, 4'b0110, 4'b0110};
    tbl[7]  = '{0, 1, 1, 2'd1, 4'h0, 0, 2'd0, 0, 4'h0, 4'b0100, 4'b0110};
    tbl[8]  = '{0, 1, 1, 2'd1, 4'h1, 0, 2'd0, 0, 4'h0, 4'b0110, 4'b0110};
    tbl[9]  = '{0, 1, 1, 2'd1, 4'h1, 0, 2'd0, 0, 4'h0, 4'b0110, 4'b0110};
    tbl[10] = '{0, 0, 0, 2'd0, 4'h0, 1, 2'd1, 1, 4'hB, 4'b0110, 4'b0110};
    tbl[11] = '{0, 1, 1, 2'd1, 4'hE, 1, 2'd1, 1, 4'hB, 4'b0100, 4'b0110};
    tbl[12] = '{0, 1, 0, 2'd0, 4'h5, 1, 2'd0, 0, 4'h0, 4'b0101, 4'b0111};
    tbl[13] = '{0, 0, 0, 2'd0, 4'h0, 1, 2'd0, 1, 4'h5, 4'b0101, 4'b0111};
    tbl[14] = '{0, 1, 0, 2'd3, 4'hF, 1, 2'd1, 1, 4'h6, 4'b1101, 4'b1111};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ch_valid", ch_valid, 0);
    chk("rst_en", en, 0);
    chk("rst_rd_ack", rd_ack, 0);
    chk("rst_err", err, 0);
    rst = 0;
    #1;
    chk("rst_wr_ready", wr_ready, 1);
    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].c, tbl[i].wv, tbl[i].wm, tbl[i].wch, tbl[i].wd, tbl[i].re, tbl[i].rch);
      chk($sformatf("tbl%0d_hit", i), rd_hit, tbl[i].eh);
      chk($sformatf("tbl%0d_data", i), rd_data, tbl[i].ed);
      chk($sformatf("tbl%0d_en", i), en, tbl[i].een);
      chk($sformatf("tbl%0d_valid", i), ch_valid, tbl[i].ev);
    end
    cyc(1, 1, 0, 2'd0, 4'hA, 0, 2'd0);
    n = 0;
    for (int k = 0; k < 6; k++) begin
      if (!wr_ready) n++;
      cyc(0, 1, 0, 2'd1, 4'hA, k == 0, 2'd3);
      if (k == 0) chk("clr_preread", rd_data, 4'hF);
      if (k == 3) begin
        chk("clr_valid", ch_valid, 0);
        chk("clr_en", en, 0);
      end
    end
    chk("clr_len", n, 4);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 2'(i), 4'(i + 7), 0, 2'd0);
    cyc(1, 0, 0, 2'd0, 4'h0, 0, 2'd0);
    cyc(0, 0, 0, 2'd0, 4'h0, 1, 2'd2);
    #2;
    rst = 1;
    #1;
    chk("midclr_rd_ack", rd_ack, 0);
    chk("midclr_rd_data", rd_data, 0);
    chk("midclr_valid", ch_valid, 0);
    chk("midclr_en", en, 0);
    chk("midclr_ready", wr_ready, 1);
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
    repeat (400)
      cyc($urandom_range(0, 19) == 0, 1'($urandom), 1'($urandom), 2'($urandom), 4'($urandom), 1'($urandom), 2'($urandom));
    u_wr_valid = 1; u_wr_ch = 2'd3; u_wr_data = 4'hF;
    #1;
    chk("n3_ready", u_wr_ready, 1);
    @(posedge clk);
    #1;
    chk("n3_err", u_err, 1);
    chk("n3_valid", u_ch_valid, 0);
    u_wr_ch = 2'd2; u_rd_en = 1; u_rd_ch = 2'd3;
    @(posedge clk);
    #1;
    chk("n3_err_pulse", u_err, 0);
    chk("n3_valid2", u_ch_valid, 3'b100);
    chk("n3_en", u_en, 3'b100);
    chk("n3_rd_ack", u_rd_ack, 1);
    chk("n3_rd_hit", u_rd_hit, 0);
    chk("n3_rd_data", u_rd_data, 0);
    u_wr_valid = 0; u_rd_en = 0; u_clr = 1;
    @(posedge clk);
    #1;
    u_clr = 0;
    n = 0;
    repeat (5) begin
      if (!u_wr_ready) n++;
      @(posedge clk);
      #1;
    end
    chk("n3_clr_len", n, 3);
    chk("n3_clr_valid", u_ch_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
